// File: rtl/memory_burst_if.sv
// Bus bundle between a master and the memory_burst backing-store model.
// Request fields are driven by the master; the beat and status signals are driven by the memory.
interface memory_burst_if #(
  parameter int MEM_ADDR_SIZE = 32,
  parameter int MEM_WORD_SIZE = 32,
  parameter int MEM_BURST_W   = 3
);
  logic                       req;
  logic                       wr;
  logic [MEM_ADDR_SIZE-1:0]   memAddr;
  logic [MEM_BURST_W-1:0]     memBurstLen;
  logic [MEM_WORD_SIZE-1:0]   memDataIn;
  logic [MEM_WORD_SIZE/8-1:0] memByteEn;
  logic                       memBusy;
  logic                       memBeat;
  logic [MEM_BURST_W-1:0]     memBeatIdx;
  logic                       memLast;
  logic [MEM_WORD_SIZE-1:0]   memDataOut;
  logic                       memErr;

  modport master (
    output req, wr, memAddr, memBurstLen, memDataIn, memByteEn,
    input  memBusy, memBeat, memBeatIdx, memLast, memDataOut, memErr
  );

  modport slave (
    input  req, wr, memAddr, memBurstLen, memDataIn, memByteEn,
    output memBusy, memBeat, memBeatIdx, memLast, memDataOut, memErr
  );
endinterface

// File: rtl/memory_burst.sv
// Behavioural burst memory: fixed access latency, incrementing wrapping bursts, byte enables.
// Optional MEM_RANGE_CHECK_EN rejects out-of-range bursts with a one-cycle memErr pulse.
module memory_burst #(
  parameter int MEM_ADDR_SIZE  = 32,
  parameter int MEM_WORD_SIZE  = 32,
  parameter int MEM_DEPTH      = 256,
  parameter int MEM_BURST_W    = 3,
  parameter int MEM_WR_LATENCY = 2,
  parameter int MEM_RD_LATENCY = 2
) (
  input  logic          clk,
  input  logic          reset,
  memory_burst_if.slave bus
);
  localparam int IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int BYTES   = MEM_WORD_SIZE / 8;
  localparam int MAX_LAT = (MEM_WR_LATENCY > MEM_RD_LATENCY) ? MEM_WR_LATENCY : MEM_RD_LATENCY;
  localparam int LAT_W   = $clog2(MAX_LAT) + 1;

  typedef enum logic [1:0] {IDLE, WAIT, XFER, ERR} state_t;

  state_t                   state_q, state_d;
  logic                     wr_q, wr_d;
  logic [IDX_W-1:0]         ptr_q, ptr_d, ptr_nxt;
  logic [MEM_BURST_W-1:0]   len_q, len_d;
  logic [MEM_BURST_W-1:0]   beat_q, beat_d;
  logic [LAT_W-1:0]         cnt_q, cnt_d;
  logic [MEM_WORD_SIZE-1:0] rdata_q, rdata_d;
  logic                     range_bad;

  logic [MEM_WORD_SIZE-1:0] mem [MEM_DEPTH];

`ifdef MEM_RANGE_CHECK_EN
  // A start address past the top also makes addr+len past the top, so one compare covers both cases.
  assign range_bad  = ({1'b0, bus.memAddr} + (MEM_ADDR_SIZE+1)'(bus.memBurstLen))
                      >= (MEM_ADDR_SIZE+1)'(MEM_DEPTH);
  assign bus.memErr = (state_q == ERR);
`else
  assign range_bad  = 1'b0;
  assign bus.memErr = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    ptr_nxt = (ptr_q == IDX_W'(MEM_DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        if (bus.req) begin
          wr_d    = bus.wr;
          ptr_d   = IDX_W'(bus.memAddr % MEM_ADDR_SIZE'(MEM_DEPTH));
          len_d   = bus.memBurstLen;
          beat_d  = '0;
          cnt_d   = bus.wr ? LAT_W'(MEM_WR_LATENCY - 1) : LAT_W'(MEM_RD_LATENCY - 1);
          state_d = range_bad ? ERR : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = XFER;
          if (!wr_q) rdata_d = mem[ptr_q];
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      XFER: begin
        ptr_d = ptr_nxt;
        if (beat_q == len_q) begin
          state_d = IDLE;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + 1'b1;
          // Read data is fetched one edge ahead so it is stable for the whole beat cycle.
          if (!wr_q) rdata_d = mem[ptr_nxt];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      ptr_q   <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is never cleared; a reset landing on a beat edge suppresses that beat's write.
  always_ff @(posedge clk) begin
    if (!reset && state_q == XFER && wr_q) begin
      for (int i = 0; i < BYTES; i++) begin
        if (bus.memByteEn[i]) mem[ptr_q][i*8 +: 8] <= bus.memDataIn[i*8 +: 8];
      end
    end
  end

  assign bus.memBusy    = (state_q != IDLE);
  assign bus.memBeat    = (state_q == XFER);
  assign bus.memBeatIdx = beat_q;
  assign bus.memLast    = (state_q == XFER) && (beat_q == len_q);
  assign bus.memDataOut = rdata_q;
endmodule

// File: tb/tb_memory_burst.sv
// Scoreboard bench for memory_burst: directed bursts push expected beats, a negedge monitor checks them.
module tb_memory_burst;
  localparam int WR_LAT = 2;
  localparam int RD_LAT = 2;

  typedef struct {
    logic [7:0]  idx;
    logic        last;
    logic        chk;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t q[$];
  exp_t me;
  logic [31:0] wdata [8];
  logic [3:0]  wbe   [8];
  logic [31:0] rexp  [8];

  memory_burst_if #(.MEM_ADDR_SIZE(32), .MEM_WORD_SIZE(32), .MEM_BURST_W(3)) bus ();

  memory_burst #(
    .MEM_ADDR_SIZE(32), .MEM_WORD_SIZE(32), .MEM_DEPTH(256), .MEM_BURST_W(3),
    .MEM_WR_LATENCY(WR_LAT), .MEM_RD_LATENCY(RD_LAT)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every beat the DUT presents must match the head of the expectation queue.
  always @(negedge clk) begin
    if (bus.memBeat === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat: idx %0d at cycle %0d with empty queue", bus.memBeatIdx, cyc);
      end else begin
        me = q.pop_front();
        chk("beat_cycle", 64'(cyc), 64'(me.cyc));
        chk("beat_idx", 64'(bus.memBeatIdx), 64'(me.idx));
        chk("beat_last", 64'(bus.memLast), 64'(me.last));
        chk("beat_busy", 64'(bus.memBusy), 64'd1);
        if (me.chk) chk("beat_rdata", 64'(bus.memDataOut), 64'(me.data));
      end
    end
  end

  task automatic push_beats(input int e0, input int lat, input int len, input int nbeats, input bit is_rd);
    exp_t e;
    for (int i = 0; i < nbeats; i++) begin
      e.idx  = 8'(i);
      e.last = (i == len);
      e.chk  = is_rd;
      e.data = is_rd ? rexp[i] : 32'h0;
      e.cyc  = e0 + lat + i;
      q.push_back(e);
    end
  endtask

  // Called at a negedge; returns at the negedge following the last beat.
  task automatic run_burst(input bit is_wr, input int addr, input int len, input bit busy_req);
    int k;
    int t;
    bus.req         = 1'b1;
    bus.wr          = is_wr;
    bus.memAddr     = 32'(addr);
    bus.memBurstLen = 3'(len);
    push_beats(cyc + 1, is_wr ? WR_LAT : RD_LAT, len, len + 1, !is_wr);
    @(negedge clk);
    bus.req = 1'b0;
    k = 0;
    t = 0;
    while (k <= len && t < 40) begin
      if (busy_req && t < 2) begin
        bus.req = 1'b1; bus.wr = 1'b1; bus.memAddr = 32'd3; bus.memBurstLen = 3'd0;
        bus.memDataIn = 32'hFFFF_FFFF; bus.memByteEn = 4'hF;
      end else if (busy_req) begin
        bus.req = 1'b0; bus.memByteEn = 4'h0;
      end
      if (bus.memBeat === 1'b1) begin
        if (is_wr) begin
          bus.memDataIn = wdata[k];
          bus.memByteEn = wbe[k];
        end
        k++;
      end
      @(negedge clk);
      t++;
    end
    bus.req = 1'b0;
    bus.memByteEn = 4'h0;
    if (t >= 40) begin
      checks++;
      failures++;
      $display("FAIL burst_timeout: saw %0d beats, wanted %0d", k, len + 1);
    end
    chk("busy_after_burst", 64'(bus.memBusy), 64'd0);
    chk("beat_after_burst", 64'(bus.memBeat), 64'd0);
    if (!is_wr) chk("rdata_hold", 64'(bus.memDataOut), 64'(rexp[len]));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    int k;
    reset = 1'b1;
    bus.req = 1'b1; bus.wr = 1'b1; bus.memAddr = 32'd7; bus.memBurstLen = 3'd0;
    bus.memDataIn = 32'h0; bus.memByteEn = 4'hF;
    repeat (3) @(negedge clk);
    chk("busy_in_reset", 64'(bus.memBusy), 64'd0);
    reset = 1'b0;
    bus.req = 1'b0;
    bus.memByteEn = 4'h0;
    repeat (4) begin
      @(negedge clk);
      chk("idle_busy", 64'(bus.memBusy), 64'd0);
      chk("idle_beat", 64'(bus.memBeat), 64'd0);
    end
    chk("rst_last", 64'(bus.memLast), 64'd0);
    chk("rst_dout", 64'(bus.memDataOut), 64'd0);
    chk("rst_err", 64'(bus.memErr), 64'd0);
    chk("rst_idx", 64'(bus.memBeatIdx), 64'd0);

    // Single word write then read back
    wdata[0] = 32'hDEAD_BEEF; wbe[0] = 4'hF;
    run_burst(1'b1, 5, 0, 1'b0);
    rexp[0] = 32'hDEAD_BEEF;
    run_burst(1'b0, 5, 0, 1'b0);

    // Eight-beat burst
    for (int i = 0; i < 8; i++) begin
      wdata[i] = 32'h100 + 32'(i);
      wbe[i]   = 4'hF;
      rexp[i]  = 32'h100 + 32'(i);
    end
    run_burst(1'b1, 16, 7, 1'b0);
    run_burst(1'b0, 16, 7, 1'b0);

    // Byte enables merge
    wdata[0] = 32'h1122_3344; wbe[0] = 4'hF;
    run_burst(1'b1, 3, 0, 1'b0);
    wdata[0] = 32'hAABB_CCDD; wbe[0] = 4'b0101;
    run_burst(1'b1, 3, 0, 1'b0);
    rexp[0] = 32'h11BB_33DD;
    run_burst(1'b0, 3, 0, 1'b0);

    // Wrap across the top of the array
    wdata[0] = 32'hCAFE_0000; wbe[0] = 4'hF;
    run_burst(1'b1, 0, 0, 1'b0);
`ifdef MEM_RANGE_CHECK_EN
    bus.req = 1'b1; bus.wr = 1'b1; bus.memAddr = 32'd254; bus.memBurstLen = 3'd3;
    bus.memDataIn = 32'h200; bus.memByteEn = 4'hF;
    @(negedge clk);
    bus.req = 1'b0;
    chk("err_busy", 64'(bus.memBusy), 64'd1);
    chk("err_pulse", 64'(bus.memErr), 64'd1);
    @(negedge clk);
    bus.memByteEn = 4'h0;
    chk("err_busy_drop", 64'(bus.memBusy), 64'd0);
    chk("err_pulse_drop", 64'(bus.memErr), 64'd0);
    repeat (4) @(negedge clk);
    rexp[0] = 32'hCAFE_0000;
    run_burst(1'b0, 0, 0, 1'b0);
`else
    for (int i = 0; i < 4; i++) begin
      wdata[i] = 32'h200 + 32'(i);
      wbe[i]   = 4'hF;
      rexp[i]  = 32'h200 + 32'(i);
    end
    run_burst(1'b1, 254, 3, 1'b0);
    run_burst(1'b0, 254, 3, 1'b0);
    rexp[0] = 32'h202;
    run_burst(1'b0, 0, 0, 1'b0);
    chk("err_tied_low", 64'(bus.memErr), 64'd0);
`endif

    // Reset during an eight-beat write: beats 0 and 1 commit, beat 2 is cut off by reset
    wdata[0] = 32'hA0; wdata[1] = 32'hA1; wdata[2] = 32'hA2;
    wbe[0] = 4'hF; wbe[1] = 4'hF; wbe[2] = 4'hF;
    run_burst(1'b1, 32, 2, 1'b0);
    bus.req = 1'b1; bus.wr = 1'b1; bus.memAddr = 32'd32; bus.memBurstLen = 3'd7;
    push_beats(cyc + 1, WR_LAT, 7, 3, 1'b0);
    @(negedge clk);
    bus.req = 1'b0;
    k = 0;
    t = 0;
    while (k < 3 && t < 40) begin
      if (bus.memBeat === 1'b1) begin
        bus.memDataIn = 32'h300 + 32'(k);
        bus.memByteEn = 4'hF;
        if (k == 2) reset = 1'b1;
        k++;
      end
      @(negedge clk);
      t++;
    end
    if (t >= 40) begin
      checks++;
      failures++;
      $display("FAIL reset_burst_timeout: saw %0d beats", k);
    end
    reset = 1'b0;
    bus.memByteEn = 4'h0;
    chk("abort_busy", 64'(bus.memBusy), 64'd0);
    chk("abort_beat", 64'(bus.memBeat), 64'd0);
    chk("abort_dout", 64'(bus.memDataOut), 64'd0);
    repeat (3) @(negedge clk);
    chk("abort_stays_idle", 64'(bus.memBusy), 64'd0);
    rexp[0] = 32'h300; rexp[1] = 32'h301; rexp[2] = 32'hA2;
    run_burst(1'b0, 32, 2, 1'b0);

    // A write request raised while a read is in flight is dropped
    rexp[0] = 32'h100; rexp[1] = 32'h101;
    run_burst(1'b0, 16, 1, 1'b1);
    repeat (2) @(negedge clk);
    chk("ignored_req_busy", 64'(bus.memBusy), 64'd0);
    rexp[0] = 32'h11BB_33DD;
    run_burst(1'b0, 3, 0, 1'b0);

    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
